// File: rtl/qspi_xip_line_reader.sv
// Byte reader over QSPI flash: one cached line answers hits in 1 cycle; misses fetch the line with Quad I/O Fast Read (0xEB).
// Accepts requests only in IDLE (req_ready); once the flash is in continuous-read mode, later misses skip the command byte.
module qspi_xip_line_reader #(
    parameter int ADDR_W      = 24,
    parameter int LINE_BYTES  = 4,
    parameter int DUMMY_CLKS  = 4,
    parameter int RD_LAT      = 1,
    parameter int CS_HIGH_MIN = 2,
    parameter bit XIP_EN      = 1'b1
) (
    input  logic              spiclk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    output logic [7:0]        rsp_data,
    input  logic              flush,
    output logic              busy,
    output logic              spiclken,
    output logic              spiss,
    output logic [3:0]        spiout,
    output logic [3:0]        spioe,
    input  logic [3:0]        spiin
);
    localparam int OFF_LOG = $clog2(LINE_BYTES);
    localparam int OFF_W   = (OFF_LOG > 0) ? OFF_LOG : 1;
    localparam int TAG_W   = ADDR_W - OFF_LOG;
    localparam int NIB_W   = $clog2(2 * LINE_BYTES);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_BYTES - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_RECOV, S_CMD, S_ADDR, S_MODE, S_DUMMY, S_READ, S_LAT, S_RESP, S_GAP
    } state_t;

    state_t                       r_state, w_nxt;
    logic [15:0]                  r_cnt, w_len;
    logic                         w_last;
    logic                         r_line_vld, r_flush_pend, r_xip_act, r_recov_pend, r_hit_vld;
    logic [TAG_W-1:0]             r_tag, w_req_tag;
    logic [OFF_W-1:0]             r_off, w_req_off;
    logic [ADDR_W-1:0]            r_base, w_addr_sh;
    logic [2*LINE_BYTES-1:0][3:0] r_line;
    logic [NIB_W-1:0]             r_cap, w_nib_hi, w_nib_lo;
    logic [RD_LAT-1:0]            r_rd_pipe;
    logic                         w_accept, w_hit, w_miss;
    logic [7:0]                   w_cmd_sh;

    assign w_req_tag = TAG_W'(req_addr >> OFF_LOG);
    assign w_req_off = OFF_W'(req_addr & OFF_MASK);
    assign w_accept  = req_valid && req_ready;
    // A flush in the same cycle as a request forces the miss path.
    assign w_hit     = w_accept && r_line_vld && !flush && (w_req_tag == r_tag);
    assign w_miss    = w_accept && !w_hit;

    always_comb begin
        w_len = 16'd1;
        case (r_state)
            S_RECOV, S_CMD: w_len = 16'd8;
            S_ADDR:         w_len = 16'(ADDR_W / 4);
            S_MODE:         w_len = 16'd2;
            S_DUMMY:        w_len = 16'(DUMMY_CLKS);
            S_READ:         w_len = 16'(2 * LINE_BYTES);
            S_LAT:          w_len = 16'(RD_LAT);
            S_GAP:          w_len = 16'(CS_HIGH_MIN);
            default:        w_len = 16'd1;
        endcase
    end
    assign w_last = (r_cnt + 16'd1) >= w_len;

    always_ff @(posedge spiclk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_miss) w_nxt = r_recov_pend ? S_RECOV : (r_xip_act ? S_ADDR : S_CMD);
            S_RECOV: if (w_last) w_nxt = S_GAP;
            S_CMD:   if (w_last) w_nxt = S_ADDR;
            S_ADDR:  if (w_last) w_nxt = S_MODE;
            S_MODE:  if (w_last) w_nxt = S_DUMMY;
            S_DUMMY: if (w_last) w_nxt = S_READ;
            S_READ:  if (w_last) w_nxt = S_LAT;
            S_LAT:   if (w_last) w_nxt = S_RESP;
            S_RESP:  w_nxt = S_GAP;
            S_GAP:   if (w_last) w_nxt = r_recov_pend ? S_CMD : S_IDLE;
            default: w_nxt = S_IDLE;
        endcase
    end

    assign w_cmd_sh  = 8'hEB << r_cnt[2:0];
    assign w_addr_sh = r_base << {r_cnt, 2'b00};

    always_comb begin
        spiss    = 1'b0;
        spiclken = 1'b0;
        spiout   = 4'h0;
        spioe    = 4'h0;
        case (r_state)
            S_RECOV: begin spiss = 1'b1; spiclken = 1'b1; spiout = 4'hF; spioe = 4'hF; end
            S_CMD:   begin spiss = 1'b1; spiclken = 1'b1; spiout = {3'b000, w_cmd_sh[7]}; spioe = 4'b0001; end
            S_ADDR:  begin spiss = 1'b1; spiclken = 1'b1; spiout = w_addr_sh[ADDR_W-1 -: 4]; spioe = 4'hF; end
            S_MODE:  begin
                spiss = 1'b1; spiclken = 1'b1; spioe = 4'hF;
                spiout = XIP_EN ? ((r_cnt == 16'd0) ? 4'h2 : 4'h0) : 4'hF;
            end
            S_DUMMY, S_READ: begin spiss = 1'b1; spiclken = 1'b1; end
            S_LAT:   spiss = 1'b1;
            default: ;
        endcase
    end

    // Captures trail the READ cycles by RD_LAT, so they keep running through LAT.
    always_ff @(posedge spiclk) begin
        if (reset) begin
            r_cnt        <= 16'd0;
            r_line_vld   <= 1'b0;
            r_flush_pend <= 1'b0;
            r_xip_act    <= 1'b0;
            r_recov_pend <= XIP_EN;
            r_hit_vld    <= 1'b0;
            r_tag        <= '0;
            r_off        <= '0;
            r_base       <= '0;
            r_line       <= '0;
            r_cap        <= '0;
            r_rd_pipe    <= '0;
        end else begin
            r_cnt     <= (w_nxt != r_state || r_state == S_IDLE) ? 16'd0 : r_cnt + 16'd1;
            r_hit_vld <= w_hit;
            r_rd_pipe <= (r_rd_pipe << 1) | RD_LAT'(r_state == S_READ);
            if (r_rd_pipe[RD_LAT-1]) begin
                r_line[r_cap ^ NIB_W'(1)] <= spiin;
                r_cap                     <= r_cap + NIB_W'(1);
            end
            if (w_hit) r_off <= w_req_off;
            if (w_miss) begin
                r_tag        <= w_req_tag;
                r_off        <= w_req_off;
                r_base       <= req_addr & ~OFF_MASK;
                r_cap        <= '0;
                r_flush_pend <= 1'b0;
            end else if (flush && r_state != S_IDLE) begin
                r_flush_pend <= 1'b1;
            end
            if (r_state == S_RESP) begin
                r_line_vld <= !(r_flush_pend || flush);
                r_xip_act  <= XIP_EN;
            end else if (flush || w_miss) begin
                r_line_vld <= 1'b0;
            end
            if (r_state == S_GAP && w_last) r_recov_pend <= 1'b0;
        end
    end

    assign w_nib_hi  = NIB_W'({r_off, 1'b1});
    assign w_nib_lo  = NIB_W'({r_off, 1'b0});
    assign req_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign rsp_valid = (r_state == S_RESP) || r_hit_vld;
    assign rsp_data  = rsp_valid ? {r_line[w_nib_hi], r_line[w_nib_lo]} : 8'h00;
endmodule
